dcache_port_arbiter: RTL and testbench

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

---
 rtl/dcache_port_arbiter_pkg.sv | 23 ++
 rtl/dcache_port_arbiter_rr_arb_select.sv | 28 ++
 rtl/dcache_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM states, transaction-ID
// type and the fixed requester indices.
package dcache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultTidWidth = 2;
    typedef logic [DefaultTidWidth-1:0] tid_t;

    // Requester indices; index 0 is the lowest.
    localparam int unsigned LOAD  = 0;
    localparam int unsigned STORE = 1;
    localparam int unsigned PTW   = 2;

    function automatic int unsigned ptr_width(input int unsigned nr_ports);
        return (nr_ports > 1) ? $clog2(nr_ports) : 1;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_arb_select.sv
// Combinational round-robin pick: the first requester at or after ptr
// (wrapping) wins; the result is one-hot, or zero when nobody requests.
module rr_arb_select
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts  = 3,
    parameter int unsigned PtrWidth = ptr_width(NrPorts)
) (
    input  logic [NrPorts-1:0]  req,
    input  logic [PtrWidth-1:0] ptr,
    output logic [NrPorts-1:0]  gnt
);

    logic [2*NrPorts-1:0] req_dbl;
    logic [2*NrPorts-1:0] gnt_dbl;
    logic [NrPorts-1:0]   req_rot;
    logic [NrPorts-1:0]   gnt_rot;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NrPorts-1:0];
        gnt_rot = req_rot & (~req_rot + NrPorts'(1));
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
        gnt     = gnt_dbl[2*NrPorts-1:NrPorts];
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates load/store/PTW requesters onto one tagged downstream port,
// bounds outstanding transactions and supports draining on flush.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts        = 3,
    parameter int unsigned AddrWidth      = 34,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 7
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    output logic                                flush_done_o,
    input  logic [NrPorts-1:0]                  req_i,
    output logic [NrPorts-1:0]                  gnt_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NrPorts-1:0]                  we_i,
    input  logic [NrPorts-1:0][DataWidth/8-1:0] be_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   wdata_i,
    output logic [NrPorts-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                mem_req_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic                                mem_we_o,
    output logic [DataWidth/8-1:0]              mem_be_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [TidWidth-1:0]                 mem_tid_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_rvalid_i,
    input  logic [TidWidth-1:0]                 mem_rtid_i,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int unsigned PtrWidth = ptr_width(NrPorts);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    typedef struct packed {
        logic [NrPorts-1:0]     win;
        logic [TidWidth-1:0]    tid;
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
    } payload_t;

    arb_state_e          state_q, state_d;
    logic [PtrWidth-1:0] rr_ptr_q, ptr_next;
    logic [CntWidth-1:0] outstanding_q, cnt_d;
    payload_t            pay_q, pay_d;
    logic                flush_done_q, flush_done_d;
    logic [NrPorts-1:0]  sel_oh;
    logic                load_payload;
    logic                issue_done;
    logic                rsp_ok;
    logic                live;

    rr_arb_select #(
        .NrPorts  (NrPorts),
        .PtrWidth (PtrWidth)
    ) u_rr_arb_select (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (sel_oh)
    );

    always_comb begin
        pay_d     = '0;
        pay_d.win = sel_oh;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            if (sel_oh[i]) begin
                pay_d.tid   = TidWidth'(i);
                pay_d.addr  = addr_i[i];
                pay_d.we    = we_i[i];
                pay_d.be    = be_i[i];
                pay_d.wdata = wdata_i[i];
            end
        end
    end

    always_comb begin
        ptr_next = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            if (pay_q.win[i]) ptr_next = (i == NrPorts - 1) ? '0 : PtrWidth'(i + 1);
        end
    end

    // A response with nothing outstanding is a protocol error; the count stays at zero.
    always_comb begin
        rsp_ok = mem_rvalid_i && (outstanding_q != '0);
        unique case ({issue_done, rsp_ok})
            2'b10:   cnt_d = outstanding_q + CntWidth'(1);
            2'b01:   cnt_d = outstanding_q - CntWidth'(1);
            default: cnt_d = outstanding_q;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        load_payload = 1'b0;
        issue_done   = 1'b0;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if ((|req_i) && (outstanding_q < MaxCnt)) begin
                    load_payload = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    issue_done = 1'b1;
                    state_d    = flush_i ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (cnt_d == '0) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            // NOTE: the payload is a plain register, not a memory, so it is reset to keep mem_* outputs defined.
            pay_q         <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= cnt_d;
            flush_done_q  <= flush_done_d;
            if (load_payload) pay_q    <= pay_d;
            if (issue_done)   rr_ptr_q <= ptr_next;
        end
    end

    // Every output is forced low while reset is held, including the pass-through response path.
    assign live         = !rst_i;
    assign mem_req_o    = live && (state_q == REQ);
    assign mem_addr_o   = live ? pay_q.addr  : '0;
    assign mem_we_o     = live && pay_q.we;
    assign mem_be_o     = live ? pay_q.be    : '0;
    assign mem_wdata_o  = live ? pay_q.wdata : '0;
    assign mem_tid_o    = live ? pay_q.tid   : '0;
    assign gnt_o        = (mem_req_o && mem_gnt_i) ? pay_q.win : '0;
    assign rdata_o      = live ? mem_rdata_i : '0;
    assign flush_done_o = live && flush_done_q;

    always_comb begin
        rvalid_o = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            rvalid_o[i] = live && mem_rvalid_i && (mem_rtid_i == TidWidth'(i));
        end
    end

    rsp_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && (outstanding_q == '0))
    );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    localparam int N    = 3;
    localparam int AW   = 34;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int TW   = 2;
    localparam int MAXO = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  flush_done;
    logic [N-1:0]          req, gnt;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0]          we;
    logic [N-1:0][BW-1:0]  be;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0]          rvalid;
    logic [DW-1:0]         rdata;
    logic                  mem_req, mem_we, mgnt, rv;
    logic [AW-1:0]         mem_addr;
    logic [BW-1:0]         mem_be;
    logic [DW-1:0]         mem_wdata, mrdata;
    logic [TW-1:0]         mem_tid, rtid;

    int checks = 0;
    int errors = 0;

    dcache_port_arbiter #(
        .NrPorts(N), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_done_o(flush_done),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_tid_o(mem_tid), .mem_gnt_i(mgnt),
        .mem_rvalid_i(rv), .mem_rtid_i(rtid), .mem_rdata_i(mrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush = 1'b0; req = '0; mgnt = 1'b0; rv = 1'b0; rtid = '0; mrdata = '0;
        addr = '0; we = '0; be = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        advance();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic          mgnt;
        logic          rv;
        logic [TW-1:0] rtid;
        logic [N-1:0]  exp_gnt;
        logic          exp_mreq;
        logic [TW-1:0] exp_tid;
        logic [N-1:0]  exp_rvalid;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    // Transaction-level reference state for the random run.
    int              m_cnt, m_ptr, m_win;
    bit              m_pend, m_drain, m_done;
    logic [AW-1:0]   m_addr;
    logic            m_we;
    logic [BW-1:0]   m_be;
    logic [DW-1:0]   m_wdata;

    initial begin
        int grants;
        int idx;
        int new_cnt;
        bit issue, dec, found, done_next;
        logic [N-1:0] e_gnt, e_rv;

        // Req 0,1,2,0 rotation with continuous grant, then routed responses.
        vecs[0] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 3'b000};
        vecs[1] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 2'd0, 3'b000};
        vecs[2] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 3'b000};
        vecs[3] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 2'd1, 3'b000};
        vecs[4] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 3'b000};
        vecs[5] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b100, 1'b1, 2'd2, 3'b000};
        vecs[6] = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b000, 1'b0, 2'd0, 3'b100};
        vecs[7] = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 2'd0, 3'b001};
        vecs[8] = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 3'b000};
        vecs[9] = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 3'b010};

        // Outputs held low during reset, even with active inputs.
        rst = 1'b1;
        clear_inputs();
        req = '1; mgnt = 1'b1; rv = 1'b1; rtid = 2'd1; mrdata = 32'hdead_beef; flush = 1'b1;
        settle();
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_flush_done", 64'(flush_done), 64'(0));
        advance();
        clear_inputs();
        advance();
        rst = 1'b0;
        settle();
        check("post_rst_mem_req", 64'(mem_req), 64'(0));
        check("post_rst_state", 64'(int'(dut.state_q)), 64'(int'(IDLE)));
        check("post_rst_cnt", 64'(dut.outstanding_q), 64'(0));
        advance();

        for (int i = 0; i < NV; i++) begin
            req = vecs[i].req; mgnt = vecs[i].mgnt; rv = vecs[i].rv; rtid = vecs[i].rtid;
            mrdata = $urandom;
            settle();
            check($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_mem_req", i), 64'(mem_req), 64'(vecs[i].exp_mreq));
            if (vecs[i].exp_mreq) check($sformatf("vec%0d_tid", i), 64'(mem_tid), 64'(vecs[i].exp_tid));
            check($sformatf("vec%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rvalid));
            check($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(mrdata));
            advance();
        end
        clear_inputs();
        settle();
        check("vec_final_cnt", 64'(dut.outstanding_q), 64'(1));
        advance();

        // Stalled grant: payload must not follow the requester's changing inputs.
        do_reset();
        addr[0] = 34'h1_2345_6780; we[0] = 1'b1; be[0] = 4'hf; wdata[0] = 32'hcafe_0001;
        req = 3'b001;
        advance();
        req = 3'b000; addr[0] = 34'h2_0000_0004; we[0] = 1'b0; flush = 1'b0;
        grants = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("stall%0d_mem_req", k), 64'(mem_req), 64'(1));
            check($sformatf("stall%0d_addr", k), 64'(mem_addr), 64'(34'h1_2345_6780));
            check($sformatf("stall%0d_we", k), 64'(mem_we), 64'(1));
            if (gnt != '0) grants++;
            advance();
            addr[0] = addr[0] + 34'h4;
        end
        mgnt = 1'b1;
        settle();
        check("stall_gnt", 64'(gnt), 64'(3'b001));
        check("stall_wdata", 64'(mem_wdata), 64'(32'hcafe_0001));
        if (gnt != '0) grants++;
        advance();
        settle();
        if (gnt != '0) grants++;
        check("stall_after_mem_req", 64'(mem_req), 64'(0));
        advance();
        check("stall_single_gnt", 64'(grants), 64'(1));

        // Outstanding limit, release by one response, simultaneous issue and response.
        do_reset();
        req = 3'b001; mgnt = 1'b1;
        grants = 0;
        for (int k = 0; k < 14; k++) begin
            settle();
            if (gnt[0]) grants++;
            advance();
        end
        check("limit_issued", 64'(grants), 64'(7));
        check("limit_cnt", 64'(dut.outstanding_q), 64'(7));
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("limit_blocked%0d", k), 64'(mem_req), 64'(0));
            advance();
        end
        rv = 1'b1; rtid = 2'd1;
        settle();
        check("limit_rsp_rvalid", 64'(rvalid), 64'(3'b010));
        advance();
        rv = 1'b0;
        settle();
        check("limit_select_cycle", 64'(mem_req), 64'(0));
        advance();
        rv = 1'b1; rtid = 2'd0;
        settle();
        check("limit_reissue", 64'(mem_req), 64'(1));
        check("limit_reissue_gnt", 64'(gnt), 64'(3'b001));
        check("limit_simul_rvalid", 64'(rvalid), 64'(3'b001));
        advance();
        rv = 1'b0; req = 3'b000;
        check("limit_simul_hold", 64'(dut.outstanding_q), 64'(6));

        // Drain with three outstanding, then flush held across a return to IDLE.
        do_reset();
        req = 3'b001; mgnt = 1'b1;
        for (int k = 0; k < 6; k++) advance();
        check("drain_start_cnt", 64'(dut.outstanding_q), 64'(3));
        req = 3'b111; flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("drain_idle%0d_req", k), 64'(mem_req), 64'(0));
            check($sformatf("drain_idle%0d_done", k), 64'(flush_done), 64'(0));
            advance();
        end
        rv = 1'b1; rtid = 2'd0;
        settle();
        check("drain_rsp1_done", 64'(flush_done), 64'(0));
        advance();
        rv = 1'b0;
        advance();
        rv = 1'b1; rtid = 2'd1;
        advance();
        rv = 1'b0;
        settle();
        check("drain_gap_req", 64'(mem_req), 64'(0));
        advance();
        rv = 1'b1; rtid = 2'd2; flush = 1'b0; req = 3'b000;
        settle();
        check("drain_rsp3_done", 64'(flush_done), 64'(0));
        check("drain_rsp3_req", 64'(mem_req), 64'(0));
        advance();
        rv = 1'b0;
        settle();
        check("drain_done_pulse", 64'(flush_done), 64'(1));
        advance();
        settle();
        check("drain_done_once", 64'(flush_done), 64'(0));
        advance();
        flush = 1'b1; req = 3'b111;
        advance();
        settle();
        check("reentry_decide", 64'(flush_done), 64'(0));
        advance();
        settle();
        check("reentry_pulse1", 64'(flush_done), 64'(1));
        advance();
        settle();
        check("reentry_no_issue", 64'(mem_req), 64'(0));
        advance();
        flush = 1'b0; req = 3'b000;
        settle();
        check("reentry_pulse2", 64'(flush_done), 64'(1));
        advance();

        // Reset in the middle of a stalled request.
        do_reset();
        req = 3'b001; mgnt = 1'b1;
        advance();
        advance();
        mgnt = 1'b0;
        advance();
        settle();
        check("rstreq_pre_req", 64'(mem_req), 64'(1));
        check("rstreq_pre_cnt", 64'(dut.outstanding_q), 64'(1));
        rst = 1'b1;
        #1;
        check("rstreq_gated", 64'(mem_req), 64'(0));
        advance();
        rst = 1'b0; req = 3'b000;
        settle();
        check("rstreq_mem_req", 64'(mem_req), 64'(0));
        check("rstreq_state", 64'(int'(dut.state_q)), 64'(int'(IDLE)));
        check("rstreq_cnt", 64'(dut.outstanding_q), 64'(0));
        advance();

        // Randomized run against the reference model.
        do_reset();
        m_cnt = 0; m_ptr = 0; m_win = 0; m_pend = 0; m_drain = 0; m_done = 0;
        m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            req  = N'($urandom);
            mgnt = ($urandom % 3) != 0;
            if (flush) flush = ($urandom % 4) != 0;
            else       flush = ($urandom % 40) == 0;
            for (int p = 0; p < N; p++) begin
                addr[p]  = AW'({$urandom, $urandom});
                we[p]    = 1'($urandom);
                be[p]    = BW'($urandom);
                wdata[p] = $urandom;
            end
            rv     = (m_cnt > 0) && (($urandom % 3) == 0);
            rtid   = TW'($urandom % N);
            mrdata = $urandom;

            e_gnt = (m_pend && mgnt) ? (N'(1) << m_win) : '0;
            e_rv  = rv ? (N'(1) << rtid) : '0;
            settle();
            check($sformatf("rnd%0d_mem_req", c), 64'(mem_req), 64'(m_pend));
            check($sformatf("rnd%0d_gnt", c), 64'(gnt), 64'(e_gnt));
            check($sformatf("rnd%0d_rvalid", c), 64'(rvalid), 64'(e_rv));
            check($sformatf("rnd%0d_rdata", c), 64'(rdata), 64'(mrdata));
            check($sformatf("rnd%0d_flush_done", c), 64'(flush_done), 64'(m_done));
            if (m_pend) begin
                check($sformatf("rnd%0d_tid", c), 64'(mem_tid), 64'(m_win));
                check($sformatf("rnd%0d_addr", c), 64'(mem_addr), 64'(m_addr));
                check($sformatf("rnd%0d_we", c), 64'(mem_we), 64'(m_we));
                check($sformatf("rnd%0d_be", c), 64'(mem_be), 64'(m_be));
                check($sformatf("rnd%0d_wdata", c), 64'(mem_wdata), 64'(m_wdata));
            end

            issue     = m_pend && mgnt;
            dec       = rv && (m_cnt > 0);
            new_cnt   = m_cnt + int'(issue) - int'(dec);
            done_next = 1'b0;
            if (m_pend) begin
                if (mgnt) begin
                    m_ptr   = (m_win + 1) % N;
                    m_pend  = 1'b0;
                    m_drain = flush;
                end
            end else if (m_drain) begin
                if (new_cnt == 0) begin
                    done_next = 1'b1;
                    m_drain   = 1'b0;
                end
            end else if (flush) begin
                m_drain = 1'b1;
            end else if ((req != '0) && (m_cnt < MAXO)) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (req[idx] && !found) begin
                        found   = 1'b1;
                        m_win   = idx;
                        m_addr  = addr[idx];
                        m_we    = we[idx];
                        m_be    = be[idx];
                        m_wdata = wdata[idx];
                    end
                end
                m_pend = 1'b1;
            end
            m_cnt  = new_cnt;
            m_done = done_next;
            advance();
        end
        check("rnd_final_cnt", 64'(dut.outstanding_q), 64'(m_cnt));
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
